aes_key_expander: RTL and testbench



---
 rtl/aes_key_expander.sv | 172 +++++++++++++++++
 tb/tb_aes_key_expander.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key expansion: one round key per clock, schedule held until next start.
// Optional build macro KEY_SCHED_ZEROIZE_EN: masks the schedule to zero while it is not
// valid and clears slots 1..10 when a new key is loaded.

// Combinational AES S-box lookup; table is the FIPS-197 S-box, byte 0x00 first.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [0:2047] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign out_byte = SBOX_TABLE[{in_byte, 3'b000} +: 8];

endmodule

module aes_key_expander #(
  parameter int unsigned ROUNDS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [0:127]                 key_in,
  output logic [0:128*(ROUNDS+1)-1]    schedule,
  output logic                         busy,
  output logic                         schedule_valid,
  output logic                         done
);

  localparam int unsigned KEY_W    = 128;
  localparam int unsigned NUM_KEYS = ROUNDS + 1;
  localparam int unsigned CNT_W    = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;

  // Only the AES-128 schedule is implemented.
  if (ROUNDS != 10) begin : g_rounds_check
    $error("aes_key_expander supports ROUNDS = 10 only");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] rk_q [NUM_KEYS];
  logic [KEY_W-1:0] rk_d [NUM_KEYS];
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [KEY_W-1:0] prev_rk;
  logic [31:0]      rot_word;
  logic [31:0]      sub_word;
  logic [7:0]       rcon;
  logic [31:0]      w0, w1, w2, w3;

  // Round constant for the round currently being generated.
  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign prev_rk  = rk_q[cnt_q - 4'd1];
  assign rot_word = {prev_rk[23:0], prev_rk[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .in_byte  (rot_word[8*b +: 8]),
      .out_byte (sub_word[8*b +: 8])
    );
  end

  assign w0 = prev_rk[127:96] ^ sub_word ^ {rcon, 24'h000000};
  assign w1 = w0 ^ prev_rk[95:64];
  assign w2 = w1 ^ prev_rk[63:32];
  assign w3 = w2 ^ prev_rk[31:0];

  // Next-state, counter and schedule update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rk_d    = rk_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (start) begin
          rk_d[0] = key_in;
`ifdef KEY_SCHED_ZEROIZE_EN
          for (int unsigned i = 1; i < NUM_KEYS; i++) begin
            rk_d[i] = '0;
          end
`endif
          cnt_d   = 4'd1;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        rk_d[cnt_q] = {w0, w1, w2, w3};
        if (cnt_q == CNT_W'(ROUNDS)) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          done_d  = 1'b1;
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and schedule registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        rk_q[i] <= rk_d[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_sched_out
`ifdef KEY_SCHED_ZEROIZE_EN
    assign schedule[KEY_W*i +: KEY_W] = valid_q ? rk_q[i] : '0;
`else
    assign schedule[KEY_W*i +: KEY_W] = rk_q[i];
`endif
  end

  assign busy           = busy_q;
  assign schedule_valid = valid_q;
  assign done           = done_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 style reference model plus directed vectors.
module tb_aes_key_expander;

  typedef logic [10:0][127:0] sched_t;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [0:127]   key_in;
  logic [0:1407]  schedule;
  logic           busy;
  logic           schedule_valid;
  logic           done;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [7:0] sbox_m [256];
  sched_t     m_rk    = '0;
  sched_t     m_sched = '0;
  bit         m_busy  = 1'b0;
  bit         m_valid = 1'b0;
  bit         m_done  = 1'b0;
  int         m_n     = 0;

  aes_key_expander #(.ROUNDS(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .key_in         (key_in),
    .schedule       (schedule),
    .busy           (busy),
    .schedule_valid (schedule_valid),
    .done           (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] slot(input int i);
    return schedule[128*i +: 128];
  endfunction

  // GF(2^8) arithmetic used to derive the S-box from its definition.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h01;
      logic [7:0] r, s;
      repeat (254) inv = gmul(inv, 8'(x));
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = rotl1(r);
        s = s ^ r;
      end
      sbox_m[x] = s ^ 8'h63;
    end
  endtask

  // Textbook word-oriented key expansion.
  function automatic sched_t expand_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    sched_t      r;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 11; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  // Reference behaviour advanced at each rising edge from the driven inputs.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_sched = '0; m_n = 0;
    end else if (start && !m_busy) begin
      m_rk = expand_model(key_in);
      m_sched[0] = key_in;
`ifdef KEY_SCHED_ZEROIZE_EN
      for (int j = 1; j < 11; j++) m_sched[j] = '0;
`endif
      m_n = 0; m_busy = 1'b1; m_valid = 1'b0; m_done = 1'b0;
    end else if (m_busy) begin
      m_n++;
      m_sched[m_n] = m_rk[m_n];
      m_done = (m_n == 10);
      if (m_n == 10) begin
        m_busy = 1'b0;
        m_valid = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  // Every-cycle comparison of DUT outputs with the reference.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("busy", 128'(busy), 128'(m_busy));
      check("schedule_valid", 128'(schedule_valid), 128'(m_valid));
      check("done", 128'(done), 128'(m_done));
      for (int j = 0; j < 11; j++) begin
`ifdef KEY_SCHED_ZEROIZE_EN
        check($sformatf("slot%0d", j), slot(j), m_valid ? m_sched[j] : 128'h0);
`else
        check($sformatf("slot%0d", j), slot(j), m_sched[j]);
`endif
      end
    end
  end

  // Drives start now (sampled at edge k) and checks the run up to the negedge after edge k+10.
  task automatic expand_and_check(input logic [127:0] key, input logic [127:0] lit1,
                                  input logic [127:0] lit10, input bit inject_ignored);
    int busy_cycles = 0;
    int done_cycles = 0;
    start  = 1'b1;
    key_in = key;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) done_cycles++;
      if (i == 0) begin
        start = 1'b0;
        check("valid_drops_at_start", 128'(schedule_valid), 128'h0);
`ifndef KEY_SCHED_ZEROIZE_EN
        check("slot0_is_key", slot(0), key);
`endif
      end
      if (i == 1) begin
`ifdef KEY_SCHED_ZEROIZE_EN
        check("rk1_masked", slot(1), 128'h0);
`else
        check("rk1_literal", slot(1), lit1);
`endif
      end
      if (inject_ignored && i == 3) begin
        start  = 1'b1;
        key_in = ~key;
      end
      if (inject_ignored && i == 4) start = 1'b0;
`ifdef KEY_SCHED_ZEROIZE_EN
      if (i == 5) check("sched_zero_mid_expand", slot(0), 128'h0);
`endif
      if (i == 10) begin
        check("rk1_final", slot(1), lit1);
        check("rk10_literal", slot(10), lit10);
        check("valid_at_k10", 128'(schedule_valid), 128'h1);
        check("done_at_k10", 128'(done), 128'h1);
      end
    end
    check("busy_cycles", 128'(busy_cycles), 128'd10);
    check("done_pulses", 128'(done_cycles), 128'd1);
  endtask

  initial begin
    sched_t pin;
    rst    = 1'b1;
    start  = 1'b0;
    key_in = '0;

    build_sbox();
    check("model_sbox_00", 128'(sbox_m[8'h00]), 128'h63);
    check("model_sbox_53", 128'(sbox_m[8'h53]), 128'hed);
    pin = expand_model(KEY_A);
    check("model_a_rk1", pin[1], A_RK1);
    check("model_a_rk10", pin[10], A_RK10);
    pin = expand_model(KEY_B);
    check("model_b_rk1", pin[1], B_RK1);
    check("model_b_rk10", pin[10], B_RK10);

    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_busy", 128'(busy), 128'h0);
    check("idle_valid", 128'(schedule_valid), 128'h0);
    check("idle_done", 128'(done), 128'h0);
    check("idle_sched10", slot(10), 128'h0);

    // First key with an ignored start mid-expansion, then back-to-back second key.
    expand_and_check(KEY_A, A_RK1, A_RK10, 1'b1);
    expand_and_check(KEY_B, B_RK1, B_RK10, 1'b0);
    repeat (3) @(negedge clk);
    check("ready_hold_valid", 128'(schedule_valid), 128'h1);
    check("ready_hold_rk10", slot(10), B_RK10);

    // Reset with a simultaneous start at edge k+5 aborts the expansion.
    start  = 1'b1;
    key_in = KEY_A;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
    end
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_valid", 128'(schedule_valid), 128'h0);
    check("rst_done", 128'(done), 128'h0);
    for (int j = 0; j < 11; j++) check($sformatf("rst_slot%0d", j), slot(j), 128'h0);
    repeat (2) @(negedge clk);
    check("post_rst_idle_busy", 128'(busy), 128'h0);
    check("post_rst_idle_valid", 128'(schedule_valid), 128'h0);

    expand_and_check(KEY_B, B_RK1, B_RK10, 1'b0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
